// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Retires DIGITS_PER_CYCLE Booth digits per busy cycle and holds the product until it is taken.
module booth_mult_seq #(
  parameter int WIDTH            = 16,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               unsign,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int EW  = 2 * ((WIDTH + 2) / 2);
  localparam int ND  = EW / 2;
  localparam int C   = (ND + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int SH  = 2 * DIGITS_PER_CYCLE;
  localparam int AW  = 2 * EW + 2;
  // Headroom above the extended multiplier so the last cycle's digit windows never index past the top.
  localparam int BW  = EW + 1 + SH;
  localparam int CNW = $clog2(C + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [BW-1:0]      b_q, b_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CNW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [AW-1:0]      sum;

  function automatic logic [AW-1:0] booth_pp(input logic [2:0] dig, input logic [AW-1:0] a);
    unique case (dig)
      3'b001, 3'b010: booth_pp = a;
      3'b011:         booth_pp = a << 1;
      3'b100:         booth_pp = -(a << 1);
      3'b101, 3'b110: booth_pp = -a;
      default:        booth_pp = '0;
    endcase
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign product   = product_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    // a_q is already scaled to the weight of digit 0 of this cycle; b_q window j is digit j.
    sum = acc_q;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      if (int'(cnt_q) * DIGITS_PER_CYCLE + j < ND)
        sum = sum + booth_pp(b_q[2*j +: 3], a_q << (2 * j));
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = {{(AW-WIDTH){~unsign & multiplicand[WIDTH-1]}}, multiplicand};
          b_d     = {{(BW-WIDTH-1){~unsign & multiplier[WIDTH-1]}}, multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = sum;
        a_d   = a_q << SH;
        b_d   = b_q >> SH;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNW'(C - 1)) begin
          product_d = sum[2*WIDTH-1:0];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks of booth_mult_seq across several WIDTH / DIGITS_PER_CYCLE configurations.
module tb_booth_mult_seq;

  localparam int NC = 5;
  localparam int CW_P [NC] = '{8, 8, 13, 16, 32};
  localparam int CD_P [NC] = '{1, 2, 4, 1, 2};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [NC];
  logic         out_ready [NC];
  logic         unsign_i  [NC];
  logic [63:0]  a_i       [NC];
  logic [63:0]  b_i       [NC];
  wire          in_ready  [NC];
  wire          out_valid [NC];
  wire          busy      [NC];
  wire  [127:0] prod      [NC];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar k = 0; k < NC; k++) begin : g_dut
    localparam int W = CW_P[k];
    logic [2*W-1:0] prod_w;
    booth_mult_seq #(.WIDTH(W), .DIGITS_PER_CYCLE(CD_P[k])) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid[k]),
      .in_ready     (in_ready[k]),
      .unsign       (unsign_i[k]),
      .multiplicand (a_i[k][W-1:0]),
      .multiplier   (b_i[k][W-1:0]),
      .out_valid    (out_valid[k]),
      .out_ready    (out_ready[k]),
      .product      (prod_w),
      .busy         (busy[k])
    );
    assign prod[k] = 128'(prod_w);
  end

  function automatic int c_of(input int k);
    return ((CW_P[k] + 2) / 2 + CD_P[k] - 1) / CD_P[k];
  endfunction

  function automatic logic [127:0] ref_mul(input int w, input bit uns, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [127:0] mask, ea, eb, pmask;
    mask  = (128'(1) << w) - 128'(1);
    pmask = (128'(1) << (2 * w)) - 128'(1);
    ea = 128'(a) & mask;
    eb = 128'(b) & mask;
    if (!uns && a[w-1]) ea = ea | ~mask;
    if (!uns && b[w-1]) eb = eb | ~mask;
    return (ea * eb) & pmask;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair and returns after the accept edge, scrambling the inputs afterwards.
  task automatic start_op(input int k, input bit uns, input logic [63:0] a, input logic [63:0] b,
                          input string name, output bit ok);
    int t = 0;
    while (in_ready[k] !== 1'b1 && t < 100) begin step(); t++; end
    ok = (in_ready[k] === 1'b1);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s[%0d]: in_ready never rose", name, k);
      return;
    end
    unsign_i[k] = uns; a_i[k] = a; b_i[k] = b; in_valid[k] = 1'b1;
    step();
    in_valid[k] = 1'b0;
    unsign_i[k] = ~uns;
    a_i[k] = {$urandom, $urandom};
    b_i[k] = {$urandom, $urandom};
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 200) begin step(); lat++; end
  endtask

  // Full transaction: latency, product, stability under hold, release handshake.
  task automatic do_op(input int k, input bit uns, input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] exp, input int hold, input string name,
                       output int acc_cyc);
    bit ok;
    int lat;
    logic [127:0] held;
    start_op(k, uns, a, b, name, ok);
    acc_cyc = cyc;
    if (!ok) return;
    wait_valid(k, lat);
    n_tests++;
    if (lat != c_of(k) + 1) begin
      n_fail++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, k, lat, c_of(k) + 1);
    end
    n_tests++;
    if (prod[k] !== exp) begin
      n_fail++; $display("FAIL %s[%0d] product: got %h want %h (a=%h b=%h u=%0d)",
                         name, k, prod[k], exp, a, b, uns);
    end
    held = exp;
    for (int i = 0; i < hold; i++) begin
      step();
      n_tests++;
      if (out_valid[k] !== 1'b1 || prod[k] !== held) begin
        n_fail++; $display("FAIL %s[%0d] hold: ov=%b p=%h want ov=1 p=%h", name, k, out_valid[k],
                           prod[k], held);
      end
    end
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    n_tests++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      n_fail++; $display("FAIL %s[%0d] release: ov=%b ir=%b want ov=0 ir=1", name, k,
                         out_valid[k], in_ready[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    for (int k = 0; k < NC; k++) begin
      n_tests++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || prod[k] !== '0) begin
        n_fail++; $display("FAIL reset[%0d]: ir=%b ov=%b busy=%b p=%h want 0 0 0 0", k,
                           in_ready[k], out_valid[k], busy[k], prod[k]);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < NC; k++) begin
      n_tests++;
      if (in_ready[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_release[%0d]: in_ready=%b want 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_directed();
    int c;
    do_op(0, 1'b0, 64'h80, 64'h80, 128'h4000, 1, "w8_min_sq", c);
    do_op(0, 1'b1, 64'hFF, 64'hFF, 128'hFE01, 0, "w8_uns_ff", c);
    do_op(0, 1'b0, 64'hFF, 64'hFF, 128'h0001, 0, "w8_sgn_ff", c);
    do_op(1, 1'b0, 64'hFF, 64'h01, 128'hFFFF, 0, "w8d2_sgn", c);
    do_op(1, 1'b1, 64'hFF, 64'h01, 128'h00FF, 0, "w8d2_uns", c);
    do_op(2, 1'b1, 64'h1FFF, 64'h1FFF, 128'h3FFC001, 0, "w13_uns_max", c);
    do_op(2, 1'b0, 64'h1000, 64'h0FFF, 128'h3001000, 0, "w13_sgn_mix", c);
    do_op(3, 1'b1, 64'hFFFF, 64'hFFFF, 128'hFFFE0001, 0, "w16_uns_max", c);
    do_op(3, 1'b0, 64'h0000, 64'h8000, 128'h0, 0, "w16_zero", c);
    do_op(4, 1'b0, 64'h80000000, 64'h80000000, 128'h4000000000000000, 0, "w32_min_sq", c);
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    do_op(1, 1'b0, 64'h7F, 64'h80, 128'hC080, 0, "b2b_first", c0);
    do_op(1, 1'b0, 64'h05, 64'hFD, 128'hFFF1, 0, "b2b_second", c1);
    n_tests++;
    if (c1 - c0 != c_of(1) + 2) begin
      n_fail++; $display("FAIL b2b spacing: got %0d want %0d", c1 - c0, c_of(1) + 2);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat, c;
    start_op(0, 1'b0, 64'h03, 64'h05, "bp", ok);
    wait_valid(0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1; a_i[0] = 64'(i + 9); b_i[0] = 64'(i + 2); unsign_i[0] = 1'(i);
      step();
      n_tests++;
      if (out_valid[0] !== 1'b1 || prod[0] !== 128'h000F || in_ready[0] !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: ov=%b p=%h ir=%b want ov=1 p=000f ir=0", i,
                           out_valid[0], prod[0], in_ready[0]);
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    n_tests++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: ir=%b ov=%b busy=%b want 1 0 0", in_ready[0],
                         out_valid[0], busy[0]);
    end
    do_op(0, 1'b0, 64'h7F, 64'h7F, 128'h3F01, 0, "bp_next", c);
  endtask

  task automatic test_reset_midop();
    bit ok;
    int c;
    start_op(0, 1'b0, 64'h80, 64'h80, "rst_mid", ok);
    n_tests++;
    if (busy[0] !== 1'b1 || prod[0] !== 128'h3F01) begin
      n_fail++; $display("FAIL rst_mid busy1: busy=%b p=%h want 1 3f01", busy[0], prod[0]);
    end
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || prod[0] !== '0 || in_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid in_rst: ov=%b busy=%b p=%h ir=%b want 0 0 0 0",
                         out_valid[0], busy[0], prod[0], in_ready[0]);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid release: in_ready=%b want 1", in_ready[0]);
    end
    repeat (8) begin
      step();
      n_tests++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid abandoned: ov=%b busy=%b want 0 0", out_valid[0], busy[0]);
      end
    end
    do_op(0, 1'b1, 64'h0C, 64'hA5, 128'h07BC, 0, "rst_mid_next", c);
  endtask

  task automatic run_random(input int k, input int n);
    int c;
    bit uns;
    logic [63:0] a, b;
    for (int i = 0; i < n; i++) begin
      uns = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      do_op(k, uns, a, b, ref_mul(CW_P[k], uns, a, b), $urandom_range(0, 3), "rand", c);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < NC; k++) begin
      fork
        automatic int kk = k;
        run_random(kk, 2000);
      join_none
    end
    wait fork;
  endtask

  initial begin
    #9_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NC; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; unsign_i[k] = 1'b0;
      a_i[k] = '0; b_i[k] = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
